pc_source_unit: RTL
===================

PC_SOURCE_UNIT -- requirements
Module: pc_source_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of ALU result inputs.
REQ-002 Parameter ADDR_WIDTH, default 16: PC width, word-addressed; SHALL be <= DATA_WIDTH and <= IMM_WIDTH.
REQ-003 Parameter IMM_WIDTH, default 26: width of jump immediate field.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, >= 2.
REQ-005 Parameter RESET_PC, default 0: PC value after reset and after a RAS underflow.
REQ-006 Clock and reset are fixed: one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 pc_source  in  2  next-PC select: 00 alu_out, 01 alu_reg_out, 10 immediate, 11 RAS pop.
REQ-010 pc_write  in  1  unconditional PC update.
REQ-011 pc_write_cond  in  1  PC update qualified by cond_true.
REQ-012 cond_true  in  1  branch condition (e.g. ALU zero).
REQ-013 alu_out  in  DATA_WIDTH  combinational ALU result.
REQ-014 alu_reg_out  in  DATA_WIDTH  registered ALU result.
REQ-015 immediate  in  IMM_WIDTH  jump target field.
REQ-016 ras_push  in  1  push link address pc+1 onto RAS.
REQ-017 pc  out  ADDR_WIDTH  current program counter (registered).
REQ-018 pc_updated  out  1  one-cycle pulse, high the cycle after pc was loaded.
REQ-019 ras_empty / ras_full  out  1 each  RAS occupancy flags (registered).
REQ-020 ras_overflow / ras_underflow  out  1 each  sticky error flags, cleared only by reset.

Function
REQ-021 Update condition upd = pc_write | (pc_write_cond & cond_true); when upd=0 pc SHALL hold.
REQ-022 When upd=1, pc SHALL load on the same edge: 00 alu_out[ADDR_WIDTH-1:0]; 01 alu_reg_out[ADDR_WIDTH-1:0]; 10 immediate[ADDR_WIDTH-1:0]; 11 RAS top entry.
REQ-023 Every select code SHALL be defined; no all-ones or X default.
REQ-024 Latency: one edge from upd to new pc; pc_updated high exactly the following cycle.
REQ-025 ras_push (independent of upd) SHALL push (pc+1) mod 2^ADDR_WIDTH, using pc before that edge.
REQ-026 Pop occurs only when upd=1 and pc_source=11.
REQ-027 Pop on empty: pc loads RESET_PC, ras_underflow set, count stays 0.
REQ-028 Push on full: oldest entry overwritten (circular), count stays RAS_DEPTH, ras_overflow set.
REQ-029 Simultaneous push and pop: pc loads current top; top replaced by pc+1; count unchanged; full/empty not an overflow/underflow (non-empty case).
REQ-030 Simultaneous push and pop on empty: pc loads RESET_PC, ras_underflow set, pushed value stored, count becomes 1.
REQ-031 pc+1 wraps from 2^ADDR_WIDTH-1 to 0 without a flag.
REQ-032 ras_full = (count==RAS_DEPTH); ras_empty = (count==0); count width clog2(RAS_DEPTH)+1.

Reset
REQ-033 While rst_n=0 at an edge: pc=RESET_PC, pc_updated=0, RAS count=0, top pointer=0, ras_empty=1, ras_full=0, both sticky flags=0.
REQ-034 Reset SHALL override concurrent upd/ras_push; RAS entry contents need not be cleared.
REQ-035 Reset mid-operation SHALL lose all RAS contents; first post-reset pop is an underflow.

Structure
REQ-036 Shared package pc_pkg SHALL hold the pc_source encodings (PCSRC_ALU, PCSRC_ALUREG, PCSRC_IMM, PCSRC_RAS).
REQ-037 RAS SHALL be a sub-module pc_ras (push, pop, push_data, top, empty, full, overflow, underflow), parameterised by ADDR_WIDTH and RAS_DEPTH.
REQ-038 Next-PC select and pc register SHALL remain in pc_source_unit.

Verification
REQ-039 Reset then pc_write=1, pc_source=00, alu_out=0x0000_1234 -> pc=0x1234 next edge, pc_updated pulse one cycle later.
REQ-040 pc_write_cond=1, cond_true=0, pc_source=01 -> pc holds; repeat with cond_true=1, alu_reg_out=0xABCD_0042 -> pc=0x0042.
REQ-041 pc=0x0010, ras_push=1 with pc_write, pc_source=10, immediate=0x0200 -> pc=0x0200, RAS top=0x0011; later pop -> pc=0x0011, ras_empty=1.
REQ-042 Five pushes at pc 0x0001..0x0005 (depth 4) -> ras_full=1, ras_overflow=1; four pops return 0x0006,0x0005,0x0004,0x0003.
REQ-043 Pop on empty -> pc=RESET_PC, ras_underflow=1 and stays set until rst_n=0.
REQ-044 pc=0xFFFF, ras_push, then pop -> pc=0x0000; reset asserted with upd=1 -> pc=RESET_PC, ras_empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the next-PC source select.
package pc_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUREG = 2'b01,
        PCSRC_IMM    = 2'b10,
        PCSRC_RAS    = 2'b11
    } pc_src_e;

endpackage

// File: rtl/pc_source_unit_if.sv
// Control/data bundle between the datapath and the PC source unit.
interface pc_source_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned IMM_WIDTH  = 26
);
    logic [1:0]            pc_source;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  cond_true;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [DATA_WIDTH-1:0] alu_reg_out;
    logic [IMM_WIDTH-1:0]  immediate;
    logic                  ras_push;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_updated;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ras_overflow;
    logic                  ras_underflow;

    modport master (
        output pc_source, pc_write, pc_write_cond, cond_true,
               alu_out, alu_reg_out, immediate, ras_push,
        input  pc, pc_updated, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  pc_source, pc_write, pc_write_cond, cond_true,
               alu_out, alu_reg_out, immediate, ras_push,
        output pc, pc_updated, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: overwrites the oldest entry when full,
// reports sticky overflow/underflow until reset.
module pc_ras #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  we_c;
    logic [PTR_W-1:0]      waddr_c;
    logic [PTR_W-1:0]      top_ptr_c;

    // wr_ptr is the next free slot; the top entry sits just below it.
    assign top_ptr_c = wr_ptr_q - PTR_W'(1);
    assign top       = mem_q[top_ptr_c];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we_c        = 1'b0;
        waddr_c     = wr_ptr_q;

        if (push && pop) begin
            we_c = 1'b1;
            if (empty_q) begin
                underflow_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                count_d     = CNT_W'(1);
            end else begin
                waddr_c = top_ptr_c;
            end
        end else if (pop) begin
            if (empty_q) begin
                underflow_d = 1'b1;
            end else begin
                wr_ptr_d = top_ptr_c;
                count_d  = count_q - CNT_W'(1);
            end
        end else if (push) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (full_q) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == CNT_W'(RAS_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage is not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (rst_n && we_c) begin
            mem_q[waddr_c] <= push_data;
        end
    end

    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: rtl/pc_source_unit.sv
// Program counter register with four-way next-PC select and a return-address stack.
module pc_source_unit
    import pc_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 16,
    parameter int unsigned          IMM_WIDTH  = 26,
    parameter int unsigned          RAS_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_source_unit_if.slave        bus
);
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  upd_q, upd_d;
    logic                  pc_updated_q, pc_updated_d;
    logic                  upd_c;
    logic                  pop_c;
    pc_src_e               src_c;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  ras_empty;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, bus.alu_out, bus.alu_reg_out, bus.immediate};

    assign src_c = pc_src_e'(bus.pc_source);
    assign upd_c = bus.pc_write | (bus.pc_write_cond & bus.cond_true);
    assign pop_c = upd_c && (src_c == PCSRC_RAS);

    // Next-PC select; an empty-stack pop falls back to the reset vector.
    always_comb begin
        pc_d         = pc_q;
        upd_d        = upd_c;
        pc_updated_d = upd_q;
        if (upd_c) begin
            case (src_c)
                PCSRC_ALU:    pc_d = bus.alu_out[ADDR_WIDTH-1:0];
                PCSRC_ALUREG: pc_d = bus.alu_reg_out[ADDR_WIDTH-1:0];
                PCSRC_IMM:    pc_d = bus.immediate[ADDR_WIDTH-1:0];
                PCSRC_RAS:    pc_d = ras_empty ? RESET_PC : ras_top;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            upd_q        <= 1'b0;
            pc_updated_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            upd_q        <= upd_d;
            pc_updated_q <= pc_updated_d;
        end
    end

    pc_ras #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.ras_push),
        .pop       (pop_c),
        .push_data (pc_q + ADDR_WIDTH'(1)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (bus.ras_full),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    assign bus.pc         = pc_q;
    assign bus.pc_updated = pc_updated_q;
    assign bus.ras_empty  = ras_empty;

endmodule
